// File: rtl/hour_counter_cfg.sv
// Hour counter for the clock datapath. Keeps the hour as binary 0..23, advances it every
// PRESCALE inc strobes, supports load and decrement for time setting, and decodes the hour
// into BCD tens/ones digits for a 12h or 24h display.
module hour_counter_cfg #(
  parameter int unsigned PRESCALE   = 60,
  parameter int unsigned RESET_HOUR = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       load_i,
  input  logic [4:0] load_hour_i,
  input  logic       mode_24_i,
  output logic [1:0] out_h10_o,
  output logic [3:0] out_h1_o,
  output logic       pm_o,
  output logic       carry_o,
  output logic       load_err_o
);

  // With PRESCALE = 1 a single prescaler bit is kept and pinned at zero.
  localparam int unsigned PreW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);
  localparam logic [4:0] ResetHour  = 5'(RESET_HOUR);
  localparam logic [4:0] LastHour   = 5'd23;

  logic [4:0]      hour_q, hour_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic            carry_q, carry_d;
  logic            load_err_q, load_err_d;
  logic [4:0]      disp_hour;

  // Next-state: load beats inc/dec; inc and dec together cancel out.
  always_comb begin
    hour_d     = hour_q;
    pre_d      = pre_q;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    if (load_i) begin
      if (load_hour_i <= LastHour) begin
        hour_d = load_hour_i;
        pre_d  = '0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (inc_i && !dec_i) begin
      if (pre_q == PreMax) begin
        pre_d = '0;
        if (hour_q == LastHour) begin
          hour_d  = 5'd0;
          carry_d = 1'b1;
        end else begin
          hour_d = hour_q + 5'd1;
        end
      end else begin
        pre_d = pre_q + PreW'(1);
      end
    end else if (dec_i && !inc_i) begin
      pre_d  = '0;
      hour_d = (hour_q == 5'd0) ? LastHour : hour_q - 5'd1;
    end
  end

  // State and registered pulses with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hour_q     <= ResetHour;
      pre_q      <= '0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      hour_q     <= hour_d;
      pre_q      <= pre_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  // Pick the displayed hour: 00..23 in 24h mode, 01..12 in 12h mode.
  always_comb begin
    disp_hour = hour_q;
    if (!mode_24_i) begin
      if (hour_q == 5'd0) begin
        disp_hour = 5'd12;
      end else if (hour_q > 5'd12) begin
        disp_hour = hour_q - 5'd12;
      end
    end
  end

  // Binary-to-BCD for 0..23 by range compare.
  always_comb begin
    if (disp_hour >= 5'd20) begin
      out_h10_o = 2'd2;
      out_h1_o  = 4'(disp_hour - 5'd20);
    end else if (disp_hour >= 5'd10) begin
      out_h10_o = 2'd1;
      out_h1_o  = 4'(disp_hour - 5'd10);
    end else begin
      out_h10_o = 2'd0;
      out_h1_o  = 4'(disp_hour);
    end
  end

  assign pm_o       = (hour_q >= 5'd12);
  assign carry_o    = carry_q;
  assign load_err_o = load_err_q;

endmodule

// File: tb/tb_hour_counter_cfg.sv
// Scoreboard bench for hour_counter_cfg: two instances (PRESCALE=1 and PRESCALE=60) share
// stimulus; an arithmetic reference model pushes expected outputs, a monitor pops and compares.
module tb_hour_counter_cfg;

  logic       clk = 1'b0;
  logic       rst, inc, dec, load, mode_24;
  logic [4:0] load_hour;

  logic [1:0] a_h10, b_h10;
  logic [3:0] a_h1, b_h1;
  logic       a_pm, b_pm, a_carry, b_carry, a_lerr, b_lerr;

  always #5 clk = ~clk;

  hour_counter_cfg #(.PRESCALE(1), .RESET_HOUR(0)) u_a (
    .clk_i(clk), .rst_i(rst), .inc_i(inc), .dec_i(dec), .load_i(load),
    .load_hour_i(load_hour), .mode_24_i(mode_24),
    .out_h10_o(a_h10), .out_h1_o(a_h1), .pm_o(a_pm), .carry_o(a_carry), .load_err_o(a_lerr)
  );

  hour_counter_cfg #(.PRESCALE(60), .RESET_HOUR(7)) u_b (
    .clk_i(clk), .rst_i(rst), .inc_i(inc), .dec_i(dec), .load_i(load),
    .load_hour_i(load_hour), .mode_24_i(mode_24),
    .out_h10_o(b_h10), .out_h1_o(b_h1), .pm_o(b_pm), .carry_o(b_carry), .load_err_o(b_lerr)
  );

  // {h10, h1, pm, carry, load_err}
  typedef logic [8:0] obs_t;
  typedef struct {
    obs_t  a;
    obs_t  b;
    string tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: plain integers for hour and prescale count per instance.
  int unsigned m_hour[2];
  int unsigned m_pre[2];
  int unsigned m_ps[2] = '{1, 60};
  int unsigned m_rst[2] = '{0, 7};

  function automatic obs_t expect_obs(int unsigned hour, bit m24, bit carry, bit lerr);
    int unsigned shown;
    obs_t        o;
    if (m24) shown = hour;
    else begin
      shown = hour % 12;
      if (shown == 0) shown = 12;
    end
    o = {2'(shown / 10), 4'(shown % 10), (hour >= 12), carry, lerr};
    return o;
  endfunction

  task automatic step(input bit r, input bit i, input bit d, input bit l,
                      input int unsigned lh, input bit m24, input string tag);
    exp_t e;
    obs_t ob[2];
    @(negedge clk);
    rst = r; inc = i; dec = d; load = l; load_hour = 5'(lh); mode_24 = m24;
    for (int k = 0; k < 2; k++) begin
      bit c = 1'b0;
      bit le = 1'b0;
      if (r) begin
        m_hour[k] = m_rst[k];
        m_pre[k]  = 0;
      end else if (l) begin
        if (lh <= 23) begin
          m_hour[k] = lh;
          m_pre[k]  = 0;
        end else le = 1'b1;
      end else if (i && !d) begin
        m_pre[k]++;
        if (m_pre[k] == m_ps[k]) begin
          m_pre[k]  = 0;
          m_hour[k] = (m_hour[k] + 1) % 24;
          c = (m_hour[k] == 0);
        end
      end else if (d && !i) begin
        m_pre[k]  = 0;
        m_hour[k] = (m_hour[k] + 23) % 24;
      end
      ob[k] = expect_obs(m_hour[k], m24, c, le);
    end
    e.a = ob[0];
    e.b = ob[1];
    e.tag = tag;
    q.push_back(e);
  endtask

  // Monitor: one expected entry per clock edge, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      obs_t ga, gb;
      e  = q.pop_front();
      ga = {a_h10, a_h1, a_pm, a_carry, a_lerr};
      gb = {b_h10, b_h1, b_pm, b_carry, b_lerr};
      n_cmp += 2;
      if (ga !== e.a) begin
        n_bad++;
        $display("FAIL %s inst_a(ps1): got h10/h1/pm/carry/lerr=%0d/%0d/%0b/%0b/%0b want %0d/%0d/%0b/%0b/%0b",
                 e.tag, ga[8:7], ga[6:3], ga[2], ga[1], ga[0],
                 e.a[8:7], e.a[6:3], e.a[2], e.a[1], e.a[0]);
      end
      if (gb !== e.b) begin
        n_bad++;
        $display("FAIL %s inst_b(ps60): got h10/h1/pm/carry/lerr=%0d/%0d/%0b/%0b/%0b want %0d/%0d/%0b/%0b/%0b",
                 e.tag, gb[8:7], gb[6:3], gb[2], gb[1], gb[0],
                 e.b[8:7], e.b[6:3], e.b[2], e.b[1], e.b[0]);
      end
    end
  end

  initial begin
    rst = 1'b0; inc = 1'b0; dec = 1'b0; load = 1'b0; load_hour = '0; mode_24 = 1'b1;

    // Reset, then 12h view of hour 0.
    step(1, 0, 0, 0, 0, 1, "reset");
    step(0, 0, 0, 0, 0, 1, "idle24");
    step(0, 0, 0, 0, 0, 0, "idle12");

    // Full day on the PRESCALE=1 instance, including the 19->20 step and the wrap carry.
    for (int k = 0; k < 24; k++) step(0, 1, 0, 0, 0, 1, "inc_day");
    step(0, 0, 0, 0, 0, 1, "carry_clear");

    // 12h decode points.
    step(0, 0, 0, 1, 13, 0, "load13");
    step(0, 0, 0, 1, 12, 0, "load12");
    step(0, 0, 0, 1, 0, 0, "load0");
    step(0, 0, 0, 1, 23, 0, "load23");

    // Bad load keeps the hour; load wins over inc.
    step(0, 0, 0, 1, 25, 1, "load_bad");
    step(0, 0, 0, 0, 0, 1, "lerr_clear");
    step(0, 1, 0, 1, 9, 1, "load_with_inc");

    // Decrement wrap and inc+dec cancel.
    step(0, 0, 0, 1, 0, 1, "load0b");
    step(0, 0, 1, 0, 0, 1, "dec_wrap");
    step(0, 0, 0, 1, 5, 1, "load5");
    step(0, 1, 1, 0, 0, 1, "inc_dec");

    // Prescaler on the PRESCALE=60 instance.
    step(0, 0, 0, 1, 7, 1, "load7");
    for (int k = 0; k < 59; k++) step(0, 1, 0, 0, 0, 1, "pre59");
    step(0, 1, 0, 0, 0, 1, "pre60");
    for (int k = 0; k < 30; k++) step(0, 1, 0, 0, 0, 1, "pre30");
    step(1, 0, 0, 0, 0, 1, "rst_mid");
    for (int k = 0; k < 59; k++) step(0, 1, 0, 0, 0, 1, "post_rst59");
    step(0, 1, 0, 0, 0, 1, "post_rst60");

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      int unsigned r = $urandom_range(0, 99);
      bit          rr = (r == 0);
      bit          ll = (r >= 1 && r <= 8);
      bit          ii = ($urandom_range(0, 3) != 0);
      bit          dd = ($urandom_range(0, 5) == 0);
      step(rr, ii, dd, ll, $urandom_range(0, 31), 1'($urandom_range(0, 1)), "random");
    end

    // Drain with a bounded wait.
    @(negedge clk);
    inc = 1'b0; dec = 1'b0; load = 1'b0; rst = 1'b0;
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
